// File: rtl/tl_input_conditioner_if.sv
// Signal bundle between the raw pins/controller side and the input conditioner.
// The conditioner uses the slave modport; whoever drives the pins and the ack uses master.
interface tl_input_conditioner_if;
  logic       ped_button_raw;
  logic       car_sensor_raw;
  logic       ped_ack;
  logic       pedestrian_button;
  logic       car_sensor;
  logic       ped_press;
  logic [7:0] ped_press_count;

  modport master (
    output ped_button_raw,
    output car_sensor_raw,
    output ped_ack,
    input  pedestrian_button,
    input  car_sensor,
    input  ped_press,
    input  ped_press_count
  );

  modport slave (
    input  ped_button_raw,
    input  car_sensor_raw,
    input  ped_ack,
    output pedestrian_button,
    output car_sensor,
    output ped_press,
    output ped_press_count
  );
endinterface

// File: rtl/tl_input_conditioner.sv
// Synchronises and debounces the pedestrian button and car sensor pins, latches pedestrian
// requests until acknowledged, and stretches car presence across short sensor dropouts.
module tl_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CAR_HOLD        = 8
) (
  input logic                    clk,
  input logic                    reset_n,
  tl_input_conditioner_if.slave  bus
);

  localparam logic [7:0] DebLast = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] CarHold = 8'(CAR_HOLD);

  typedef struct packed {
    logic       deb;
    logic [7:0] cnt;
  } deb_t;

  function automatic deb_t deb_next(logic sync, deb_t cur);
    deb_t nxt;
    nxt = cur;
    if (sync == cur.deb) begin
      nxt.cnt = 8'd0;
    end else if (cur.cnt == DebLast) begin
      nxt.deb = sync;
      nxt.cnt = 8'd0;
    end else begin
      nxt.cnt = cur.cnt + 8'd1;
    end
    return nxt;
  endfunction

  logic       ped_sync1_q, ped_sync2_q, car_sync1_q, car_sync2_q;
  deb_t       ped_deb_q, ped_deb_d, car_deb_q, car_deb_d;
  logic       ped_rise;
  logic       press_q, press_d;
  logic [7:0] count_q, count_d;
  logic       req_q, req_d;
  logic [7:0] hc_q, hc_d;
  logic       car_q, car_d;

  always_comb begin
    ped_deb_d = deb_next(ped_sync2_q, ped_deb_q);
    car_deb_d = deb_next(car_sync2_q, car_deb_q);
    ped_rise  = !ped_deb_q.deb && ped_deb_d.deb;

    press_d = ped_rise;
    count_d = count_q;
    if (ped_rise && (count_q != 8'hff)) begin
      count_d = count_q + 8'd1;
    end
    // A press in the same cycle as an ack wins so the new request is not lost.
    req_d = ped_rise || (req_q && !bus.ped_ack);

    hc_d  = 8'd0;
    car_d = 1'b0;
    if (car_deb_q.deb) begin
      hc_d  = CarHold;
      car_d = 1'b1;
    end else if (hc_q != 8'd0) begin
      hc_d  = hc_q - 8'd1;
      car_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_sync1_q <= 1'b0;
      ped_sync2_q <= 1'b0;
      car_sync1_q <= 1'b0;
      car_sync2_q <= 1'b0;
      ped_deb_q   <= '0;
      car_deb_q   <= '0;
      press_q     <= 1'b0;
      count_q     <= 8'd0;
      req_q       <= 1'b0;
      hc_q        <= 8'd0;
      car_q       <= 1'b0;
    end else begin
      ped_sync1_q <= bus.ped_button_raw;
      ped_sync2_q <= ped_sync1_q;
      car_sync1_q <= bus.car_sensor_raw;
      car_sync2_q <= car_sync1_q;
      ped_deb_q   <= ped_deb_d;
      car_deb_q   <= car_deb_d;
      press_q     <= press_d;
      count_q     <= count_d;
      req_q       <= req_d;
      hc_q        <= hc_d;
      car_q       <= car_d;
    end
  end

  assign bus.pedestrian_button = req_q;
  assign bus.car_sensor        = car_q;
  assign bus.ped_press         = press_q;
  assign bus.ped_press_count   = count_q;

endmodule
